// File: rtl/proc_pkg.sv
// Shared constants, opcode encodings and FSM state type
// for the memory-access / writeback stage.
package proc_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_REG_AW = 3;
  localparam int DEF_MEM_AW = 4;
  localparam int DEF_CNT_W  = 16;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b1110;
  localparam logic [3:0] OP_STORE = 4'b1111;

  typedef enum logic {
    IDLE    = 1'b0,
    LOAD_RD = 1'b1
  } state_e;

  // Anything that is not NOP/LOAD/STORE is treated as ALU.
  function automatic logic is_alu(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_LOAD) && (op != OP_STORE);
  endfunction

endpackage

// File: rtl/dmem_sync.sv
// Data memory: one write port, one synchronous read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), re_i/raddr_i (read), rdata_o.
module dmem_sync #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i)
      mem_q[waddr_i] <= wdata_i;
    if (re_i) begin
      // Write-first: a same-address write is seen by the read.
      if (we_i && (waddr_i == raddr_i))
        rdata_q <= wdata_i;
      else
        rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: loads, stores, RF write,
// forwarding bus, load stall and retired-instruction counter.
// Ports: clk, reset, EU inputs (*_i), rf_*/fwd_* write outputs,
// stall_o (high during LOAD_RD), retired_o (wrapping counter).
module mem_wb_stage
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int MEM_AW = DEF_MEM_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [REG_AW-1:0] dest_reg_i,
  input  logic              rf_we_i,
  input  logic              dmem_we_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [MEM_AW-1:0] mem_addr_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              fwd_valid_o,
  output logic [REG_AW-1:0] fwd_reg_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  retired_o
);

  state_e            state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_AW-1:0] ld_dest_q, ld_dest_d;
  logic [CNT_W-1:0]  ret_q, ret_d;

  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  logic op_load, op_store, op_alu;

  assign op_load  = (opcode_i == OP_LOAD);
  assign op_store = (opcode_i == OP_STORE);
  assign op_alu   = is_alu(opcode_i);

  dmem_sync #(
    .DW(DATA_W),
    .AW(MEM_AW)
  ) u_dmem (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(mem_addr_i),
    .wdata_i(store_data_i),
    .re_i   (mem_re),
    .raddr_i(mem_addr_i),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    rf_we_d   = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    ld_dest_d = ld_dest_q;
    ret_d     = ret_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op_load) begin
          mem_re    = 1'b1;
          ld_dest_d = dest_reg_i;
          state_d   = LOAD_RD;
        end else if (op_store) begin
          // Opcode gates the strobe so X/Z on NOP cannot write.
          mem_we = dmem_we_i;
          ret_d  = ret_q + CNT_W'(1);
        end else if (op_alu) begin
          rf_we_d = rf_we_i;
          waddr_d = dest_reg_i;
          wdata_d = result_i;
          ret_d   = ret_q + CNT_W'(1);
        end
      end
      LOAD_RD: begin
        // Inputs are ignored here; upstream is holding.
        rf_we_d = 1'b1;
        waddr_d = ld_dest_q;
        wdata_d = mem_rdata;
        ret_d   = ret_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rf_we_q   <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      ld_dest_q <= '0;
      ret_q     <= '0;
    end else begin
      state_q   <= state_d;
      rf_we_q   <= rf_we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      ld_dest_q <= ld_dest_d;
      ret_q     <= ret_d;
    end
  end

  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = waddr_q;
  assign rf_wdata_o  = wdata_q;
  assign fwd_valid_o = rf_we_q;
  assign fwd_reg_o   = waddr_q;
  assign fwd_data_o  = wdata_q;
  assign stall_o     = (state_q == LOAD_RD);
  assign retired_o   = ret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed + random bench for mem_wb_stage with a
// transaction-level reference model (CNT_W=4 build).
module tb_mem_wb_stage;
  import proc_pkg::*;

  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   opcode;
  logic [7:0]   result;
  logic [2:0]   dest;
  logic         rf_we_in;
  logic         dmem_we_in;
  logic [7:0]   sdata;
  logic [3:0]   addr;

  logic         rf_we;
  logic [2:0]   rf_waddr;
  logic [7:0]   rf_wdata;
  logic         fwd_valid;
  logic [2:0]   fwd_reg;
  logic [7:0]   fwd_data;
  logic         stall;
  logic [CW-1:0] retired;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] mem_m [16];
  int cnt_m = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode_i    (opcode),
    .result_i    (result),
    .dest_reg_i  (dest),
    .rf_we_i     (rf_we_in),
    .dmem_we_i   (dmem_we_in),
    .store_data_i(sdata),
    .mem_addr_i  (addr),
    .rf_we_o     (rf_we),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata),
    .fwd_valid_o (fwd_valid),
    .fwd_reg_o   (fwd_reg),
    .fwd_data_o  (fwd_data),
    .stall_o     (stall),
    .retired_o   (retired)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic we,
                        input logic [2:0] wa,
                        input logic [7:0] wd);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(we));
    chk({tag, ".fwd_v"}, 32'(fwd_valid), 32'(we));
    if (we) begin
      chk({tag, ".waddr"}, 32'(rf_waddr), 32'(wa));
      chk({tag, ".wdata"}, 32'(rf_wdata), 32'(wd));
      chk({tag, ".fwd_r"}, 32'(fwd_reg), 32'(wa));
      chk({tag, ".fwd_d"}, 32'(fwd_data), 32'(wd));
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".retired"}, 32'(retired), 32'(cnt_m % 16));
  endtask

  task automatic drive(input logic [3:0] op,
                       input logic [7:0] res,
                       input logic [2:0] dst,
                       input logic [7:0] sd,
                       input logic [3:0] ad);
    opcode = op;
    result = res;
    dest   = dst;
    sdata  = sd;
    addr   = ad;
    if (op == OP_NOP) begin
      rf_we_in   = 1'bz;
      dmem_we_in = 1'bz;
    end else begin
      rf_we_in   = 1'b1;
      dmem_we_in = (op == OP_STORE);
    end
  endtask

  task automatic exec(input string tag,
                      input logic [3:0] op,
                      input logic [7:0] res,
                      input logic [2:0] dst,
                      input logic [7:0] sd,
                      input logic [3:0] ad);
    @(negedge clk);
    drive(op, res, dst, sd, ad);
    @(posedge clk);
    #1;
    if (op == OP_LOAD) begin
      chk({tag, ".stall1"}, 32'(stall), 32'd1);
      chk_rf({tag, ".ld1"}, 1'b0, 3'd0, 8'd0);
      @(posedge clk);
      #1;
      cnt_m++;
      chk({tag, ".stall0"}, 32'(stall), 32'd0);
      chk_rf({tag, ".ld2"}, 1'b1, dst, mem_m[ad]);
    end else begin
      chk({tag, ".stall"}, 32'(stall), 32'd0);
      if (op == OP_NOP) begin
        chk_rf(tag, 1'b0, 3'd0, 8'd0);
      end else if (op == OP_STORE) begin
        mem_m[ad] = sd;
        cnt_m++;
        chk_rf(tag, 1'b0, 3'd0, 8'd0);
      end else begin
        cnt_m++;
        chk_rf(tag, 1'b1, dst, res);
      end
    end
    chk_cnt(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, ".waddr"}, 32'(rf_waddr), 32'd0);
    chk({tag, ".wdata"}, 32'(rf_wdata), 32'd0);
    chk({tag, ".fwd_v"}, 32'(fwd_valid), 32'd0);
    chk({tag, ".fwd_r"}, 32'(fwd_reg), 32'd0);
    chk({tag, ".fwd_d"}, 32'(fwd_data), 32'd0);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".ret"}, 32'(retired), 32'd0);
  endtask

  initial begin
    logic [3:0] op;
    logic [7:0] lval;

    // Power-on reset
    reset = 1'b1;
    drive(OP_NOP, 8'h00, 3'd0, 8'h00, 4'd0);
    #12;
    chk_zero("por");
    @(negedge clk);
    reset = 1'b0;

    // ALU op
    exec("alu", 4'b0001, 8'h5A, 3'd3, 8'h00, 4'd0);
    // Store then load same address
    exec("st4", OP_STORE, 8'h00, 3'd0, 8'hC3, 4'd4);
    exec("ld4", OP_LOAD, 8'h00, 3'd6, 8'h00, 4'd4);
    // NOP with floating strobes must not touch mem
    exec("nop", OP_NOP, 8'hEE, 3'd5, 8'hFF, 4'd4);
    exec("ld4b", OP_LOAD, 8'h00, 3'd1, 8'h00, 4'd4);

    // Initialise every word so random loads are defined
    for (int i = 0; i < 16; i++)
      exec("fill", OP_STORE, 8'h00, 3'd0,
           8'($urandom), 4'(i));

    // Back-to-back loads
    exec("bb1", OP_LOAD, 8'h00, 3'd2, 8'h00, 4'd9);
    exec("bb2", OP_LOAD, 8'h00, 3'd3, 8'h00, 4'd10);

    // ALU op presented during LOAD_RD and held
    @(negedge clk);
    drive(OP_LOAD, 8'h00, 3'd1, 8'h00, 4'd7);
    @(posedge clk);
    #1;
    chk("hold.stall", 32'(stall), 32'd1);
    @(negedge clk);
    drive(4'b0011, 8'h99, 3'd2, 8'h00, 4'd0);
    @(posedge clk);
    #1;
    cnt_m++;
    chk("hold.stall0", 32'(stall), 32'd0);
    chk_rf("hold.ld", 1'b1, 3'd1, mem_m[7]);
    @(posedge clk);
    #1;
    cnt_m++;
    chk_rf("hold.alu", 1'b1, 3'd2, 8'h99);
    chk_cnt("hold");
    @(negedge clk);
    drive(OP_NOP, 8'h00, 3'd0, 8'h00, 4'd0);
    @(posedge clk);
    #1;
    chk_rf("hold.once", 1'b0, 3'd0, 8'd0);
    chk_cnt("hold.once");

    // Reset asserted during LOAD_RD
    lval = mem_m[4];
    @(negedge clk);
    drive(OP_LOAD, 8'h00, 3'd4, 8'h00, 4'd4);
    @(posedge clk);
    #1;
    chk("rst.stall", 32'(stall), 32'd1);
    #1;
    reset = 1'b1;
    drive(OP_NOP, 8'h00, 3'd0, 8'h00, 4'd0);
    #1;
    chk_zero("rst");
    cnt_m = 0;
    @(posedge clk);
    #1;
    chk_zero("rst.hold");
    @(negedge clk);
    reset = 1'b0;
    // Memory survives reset
    exec("rst.ld", OP_LOAD, 8'h00, 3'd5, 8'h00, 4'd4);
    chk("rst.keep", 32'(rf_wdata), 32'(lval));

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: op = OP_NOP;
        1: op = OP_LOAD;
        2: op = OP_STORE;
        default: op = 4'($urandom_range(1, 13));
      endcase
      exec("rnd", op, 8'($urandom), 3'($urandom),
           8'($urandom), 4'($urandom));
    end

    // Counter wrap 15 -> 0
    @(negedge clk);
    reset = 1'b1;
    drive(OP_NOP, 8'h00, 3'd0, 8'h00, 4'd0);
    #1;
    cnt_m = 0;
    chk_zero("wrap.rst");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++)
      exec("wrap.alu", 4'b0101, 8'(i), 3'(i), 8'h00, 4'd0);
    chk("wrap.15", 32'(retired), 32'd15);
    exec("wrap.last", 4'b0110, 8'hA5, 3'd7, 8'h00, 4'd0);
    chk("wrap.0", 32'(retired), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
